// File: rtl/fmac_pkg.sv
// fmac_pkg
//   Types and default widths shared by the BFP group MAC (fmac) and its
//   sequencer fmac_grp_sched.
//   - res_t   : one captured fmac result with its row / last-group tags
//   - state_e : sequencer FSM states
//   The res_t field widths follow the *_DEF widths. Instantiate fmac_grp_sched
//   with its width parameters left at these defaults, or widen the defaults here.
package fmac_pkg;

    localparam int FPEXPSIZE_DEF = 8;   // fmac result exponent width
    localparam int FPMANSIZE_DEF = 24;  // fmac result mantissa width (sign + 23)
    localparam int ADDRW_DEF     = 10;  // act/weight buffer address width
    localparam int CNTW_DEF      = 8;   // row/group count width
    localparam int RDLAT_DEF     = 1;   // buffer read latency
    localparam int FMACLAT_DEF   = 1;   // fmac input-to-output latency
    localparam int FIFODEPTH_DEF = 4;   // result FIFO entries

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [FPEXPSIZE_DEF-1:0] exp;
        logic [FPMANSIZE_DEF-1:0] man;
        logic [CNTW_DEF-1:0]      row;
        logic                     last;
    } res_t;

endpackage

// File: rtl/fmac_res_fifo.sv
// fmac_res_fifo
//   Synchronous FIFO of res_t entries with an occupancy count.
//   Ports:
//     i_clk, i_reset_n  clock, async active-low reset (clears contents too)
//     i_push, i_data    write strobe and entry; ignored only if full and not popping
//     i_pop             read strobe; ignored while empty
//     o_valid, o_data   head valid and head entry (read from registered storage)
//     o_count           registered number of stored entries
//   A push and pop in the same cycle are both honoured and the count is unchanged.
module fmac_res_fifo
    import fmac_pkg::*;
#(
    parameter int DEPTH = FIFODEPTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_push,
    input  res_t                       i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output res_t                       o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    res_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = i_pop && (count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = i_push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];
    assign o_count = count;

endmodule

// File: rtl/fmac_grp_sched.sv
// fmac_grp_sched
//   Sequencer for the BFP group MAC. Walks an N-row x K-group job (row outer,
//   group inner), issuing act/weight buffer reads whose data lands directly on
//   the fmac inputs. fmac has no valid/stall, so every read is tracked through a
//   tag pipe of depth RDLAT+FMACLAT and its result is captured into a result
//   FIFO when the tag exits. A read is issued only when the FIFO is guaranteed
//   room for it, so downstream backpressure never loses a result.
//   Ports:
//     i_clk, i_reset_n              clock, async active-low reset
//     i_start, i_num_grp (K),       job start (sampled in IDLE only) and job
//     i_num_row (N), i_act_base,    shape / base addresses
//     i_wgt_base
//     o_busy, o_done                FSM not IDLE; one-cycle completion pulse
//     o_act_rd_en/_addr,            buffer reads (both strobes identical)
//     o_wgt_rd_en/_addr
//     i_fmac_E, i_fmac_M            fmac registered result
//     o_res_valid, i_res_ready,     result stream: head entry with row index and
//     o_res_E/_M/_row/_last         last-group-of-row flag
//     o_dbg_state                   current FSM state (state_e encoding)
//   Result handshake: an entry transfers on every cycle with
//   o_res_valid && i_res_ready; while o_res_valid is high and i_res_ready is low
//   the head entry and o_res_valid hold.
module fmac_grp_sched
    import fmac_pkg::*;
#(
    parameter int FPEXPSIZE = FPEXPSIZE_DEF,
    parameter int FPMANSIZE = FPMANSIZE_DEF,
    parameter int ADDRW     = ADDRW_DEF,
    parameter int CNTW      = CNTW_DEF,
    parameter int RDLAT     = RDLAT_DEF,
    parameter int FMACLAT   = FMACLAT_DEF,
    parameter int FIFODEPTH = FIFODEPTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [CNTW-1:0]      i_num_grp,
    input  logic [CNTW-1:0]      i_num_row,
    input  logic [ADDRW-1:0]     i_act_base,
    input  logic [ADDRW-1:0]     i_wgt_base,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_act_rd_en,
    output logic [ADDRW-1:0]     o_act_rd_addr,
    output logic                 o_wgt_rd_en,
    output logic [ADDRW-1:0]     o_wgt_rd_addr,
    input  logic [FPEXPSIZE-1:0] i_fmac_E,
    input  logic [FPMANSIZE-1:0] i_fmac_M,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [FPEXPSIZE-1:0] o_res_E,
    output logic [FPMANSIZE-1:0] o_res_M,
    output logic [CNTW-1:0]      o_res_row,
    output logic                 o_res_last,
    output logic [1:0]           o_dbg_state
);

    localparam int PIPE = RDLAT + FMACLAT;
    localparam int CW   = $clog2(FIFODEPTH + 1);
    localparam int IW   = $clog2(PIPE + 1);

    state_e           state;
    logic [CNTW-1:0]  k_q;
    logic [CNTW-1:0]  n_q;
    logic [CNTW-1:0]  g_q;
    logic [CNTW-1:0]  r_q;
    logic [ADDRW-1:0] act_base_q;
    logic [ADDRW-1:0] wgt_addr_q;   // runs r*K+g ahead of the weight base
    logic             done_q;

    logic [PIPE-1:0]  pipe_vld;
    logic [CNTW-1:0]  pipe_row [PIPE];
    logic [PIPE-1:0]  pipe_last;

    logic [CW-1:0]    fifo_cnt;
    logic [IW-1:0]    inflight_cnt;
    logic             issue;
    logic             last_grp;
    logic             last_row;
    logic             res_pop;
    res_t             push_data;
    res_t             head;

    // In-flight reads are the valid tag pipe stages.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < PIPE; i++) begin
            inflight_cnt = inflight_cnt + IW'(pipe_vld[i]);
        end
    end

    // Credit: every queued or in-flight result owns a FIFO slot. A pop in this
    // cycle is not credited, which keeps the check on registered state only.
    assign issue    = (state == ST_RUN) &&
                      ((int'(fifo_cnt) + int'(inflight_cnt)) < FIFODEPTH);
    assign last_grp = (g_q == k_q - CNTW'(1));
    assign last_row = (r_q == n_q - CNTW'(1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            k_q        <= '0;
            n_q        <= '0;
            g_q        <= '0;
            r_q        <= '0;
            act_base_q <= '0;
            wgt_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if ((i_num_grp == '0) || (i_num_row == '0)) begin
                            // Empty job: report completion without touching the buffers.
                            done_q <= 1'b1;
                        end else begin
                            k_q        <= i_num_grp;
                            n_q        <= i_num_row;
                            g_q        <= '0;
                            r_q        <= '0;
                            act_base_q <= i_act_base;
                            wgt_addr_q <= i_wgt_base;
                            state      <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        wgt_addr_q <= wgt_addr_q + ADDRW'(1);
                        if (last_grp) begin
                            g_q <= '0;
                            r_q <= r_q + CNTW'(1);
                            if (last_row) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            g_q <= g_q + CNTW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((inflight_cnt == '0) && (fifo_cnt == '0)) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag pipe: stage PIPE-1 is valid in the cycle the matching fmac result is
    // on i_fmac_E/M.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
            for (int i = 0; i < PIPE; i++) begin
                pipe_row[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= issue;
            pipe_row[0]  <= r_q;
            pipe_last[0] <= last_grp;
            for (int i = 1; i < PIPE; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_row[i]  <= pipe_row[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    assign push_data.exp  = i_fmac_E;
    assign push_data.man  = i_fmac_M;
    assign push_data.row  = pipe_row[PIPE-1];
    assign push_data.last = pipe_last[PIPE-1];
    assign res_pop        = o_res_valid && i_res_ready;

    fmac_res_fifo #(
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (pipe_vld[PIPE-1]),
        .i_data    (push_data),
        .i_pop     (res_pop),
        .o_valid   (o_res_valid),
        .o_data    (head),
        .o_count   (fifo_cnt)
    );

    assign o_busy        = (state != ST_IDLE);
    assign o_done        = done_q;
    assign o_act_rd_en   = issue;
    assign o_wgt_rd_en   = issue;
    assign o_act_rd_addr = act_base_q + ADDRW'(g_q);
    assign o_wgt_rd_addr = wgt_addr_q;
    assign o_res_E       = head.exp;
    assign o_res_M       = head.man;
    assign o_res_row     = head.row;
    assign o_res_last    = head.last;
    assign o_dbg_state   = state;

endmodule

// File: tb/tb_fmac_grp_sched.sv
// tb_fmac_grp_sched
//   Directed bench for fmac_grp_sched. A behavioural buffer + fmac model turns
//   each read address pair into a result word two cycles later; the expected
//   queues hold hand-derived addresses and the result word each address pair
//   must produce, in issue order.
module tb_fmac_grp_sched;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_start;
    logic [7:0]  i_num_grp;
    logic [7:0]  i_num_row;
    logic [9:0]  i_act_base;
    logic [9:0]  i_wgt_base;
    logic        o_busy;
    logic        o_done;
    logic        o_act_rd_en;
    logic [9:0]  o_act_rd_addr;
    logic        o_wgt_rd_en;
    logic [9:0]  o_wgt_rd_addr;
    logic [7:0]  i_fmac_E;
    logic [23:0] i_fmac_M;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [7:0]  o_res_E;
    logic [23:0] o_res_M;
    logic [7:0]  o_res_row;
    logic        o_res_last;
    logic [1:0]  o_dbg_state;

    fmac_grp_sched dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_num_grp     (i_num_grp),
        .i_num_row     (i_num_row),
        .i_act_base    (i_act_base),
        .i_wgt_base    (i_wgt_base),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_act_rd_en   (o_act_rd_en),
        .o_act_rd_addr (o_act_rd_addr),
        .o_wgt_rd_en   (o_wgt_rd_en),
        .o_wgt_rd_addr (o_wgt_rd_addr),
        .i_fmac_E      (i_fmac_E),
        .i_fmac_M      (i_fmac_M),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (i_res_ready),
        .o_res_E       (o_res_E),
        .o_res_M       (o_res_M),
        .o_res_row     (o_res_row),
        .o_res_last    (o_res_last),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int done_base = 0;

    logic [9:0]  act_exp_q[$];
    logic [9:0]  wgt_exp_q[$];
    logic [40:0] res_exp_q[$];   // {E, M, row, last}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Result the buffer + fmac model produces for one address pair.
    function automatic logic [31:0] fmac_fn(input logic [9:0] a, input logic [9:0] w);
        return {a[7:0] ^ w[7:0], w, a, 4'hA};
    endfunction

    // ---------------- buffer + fmac model ----------------
    // Read data one cycle after rd_en, registered fmac output one cycle later.
    // Cycles without a read carry a junk pattern so misaligned capture shows.
    logic [31:0] buf_d;
    logic [31:0] fmac_d;
    always @(posedge i_clk) begin
        buf_d  <= o_act_rd_en ? fmac_fn(o_act_rd_addr, o_wgt_rd_addr) : 32'hDEAD_BEEF;
        fmac_d <= buf_d;
    end
    assign i_fmac_E = fmac_d[31:24];
    assign i_fmac_M = fmac_d[23:0];

    // ---------------- monitor / scoreboard ----------------
    // Samples 1 ns after the falling edge, after that edge's stimulus settles.
    always @(negedge i_clk) begin
        logic [9:0]  ea;
        logic [9:0]  ew;
        logic [40:0] er;
        #1;
        if (i_reset_n) begin
            chk("wgt_en_eq_act_en", o_wgt_rd_en, o_act_rd_en);
            if (o_act_rd_en) begin
                rd_cnt++;
                if (act_exp_q.size() == 0) begin
                    chk("unexpected_rd_en", o_act_rd_en, 0);
                end else begin
                    ea = act_exp_q.pop_front();
                    ew = wgt_exp_q.pop_front();
                    chk("act_addr", o_act_rd_addr, ea);
                    chk("wgt_addr", o_wgt_rd_addr, ew);
                end
            end
            if (o_res_valid && i_res_ready) begin
                if (res_exp_q.size() == 0) begin
                    chk("unexpected_result", o_res_valid, 0);
                end else begin
                    er = res_exp_q.pop_front();
                    chk("res_word", {o_res_E, o_res_M, o_res_row, o_res_last}, er);
                end
            end
            if (o_done) done_cnt++;
            chk("fifo_no_overflow", dut.fifo_cnt > 3'd4, 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge i_clk);
    endtask

    task automatic push_exp(input logic [9:0] a, input logic [9:0] w,
                            input logic [7:0] row, input logic last);
        act_exp_q.push_back(a);
        wgt_exp_q.push_back(w);
        res_exp_q.push_back({fmac_fn(a, w), row, last});
    endtask

    task automatic expect_job(input int k, input int n, input logic [9:0] a, input logic [9:0] w);
        logic [9:0] wa;
        wa = w;
        for (int r = 0; r < n; r++) begin
            for (int g = 0; g < k; g++) begin
                push_exp(a + 10'(g), wa, 8'(r), g == k - 1);
                wa = wa + 10'd1;
            end
        end
    endtask

    // Called at a falling edge; returns one cycle after the start edge.
    task automatic start_job(input logic [7:0] k, input logic [7:0] n,
                             input logic [9:0] a, input logic [9:0] w);
        done_base  = done_cnt;
        i_num_grp  = k;
        i_num_row  = n;
        i_act_base = a;
        i_wgt_base = w;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == done_base; i++) tick();
        tick(3);
        chk({tag, "_done_once"}, done_cnt - done_base, 1);
        chk({tag, "_idle"}, o_busy, 0);
        chk({tag, "_rd_left"}, act_exp_q.size(), 0);
        chk({tag, "_res_left"}, res_exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rd0;
        int d0;
        i_reset_n   = 1'b0;
        i_start     = 1'b0;
        i_num_grp   = '0;
        i_num_row   = '0;
        i_act_base  = '0;
        i_wgt_base  = '0;
        i_res_ready = 1'b1;
        tick(2);
        // reset state
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_rd_en", o_act_rd_en, 0);
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_state", o_dbg_state, 2'd0);
        i_reset_n = 1'b1;
        tick(2);

        // 1: K=3, N=2, ready=1
        push_exp(10'h010, 10'h040, 8'd0, 1'b0);
        push_exp(10'h011, 10'h041, 8'd0, 1'b0);
        push_exp(10'h012, 10'h042, 8'd0, 1'b1);
        push_exp(10'h010, 10'h043, 8'd1, 1'b0);
        push_exp(10'h011, 10'h044, 8'd1, 1'b0);
        push_exp(10'h012, 10'h045, 8'd1, 1'b1);
        start_job(8'd3, 8'd2, 10'h010, 10'h040);
        chk("t1_first_rd_en", o_act_rd_en, 1);
        chk("t1_busy", o_busy, 1);
        chk("t1_state_run", o_dbg_state, 2'd1);
        tick(2);
        chk("t1_res_not_early", o_res_valid, 0);
        tick();
        chk("t1_res_latency", o_res_valid, 1);
        wait_done("t1", 60);

        // 2: K=8, N=1, ready=0 stalls after four reads
        i_res_ready = 1'b0;
        rd0 = rd_cnt;
        expect_job(8, 1, 10'h020, 10'h080);
        start_job(8'd8, 8'd1, 10'h020, 10'h080);
        tick(12);
        chk("t2_stall_rd_cnt", rd_cnt - rd0, 4);
        chk("t2_stall_rd_en", o_act_rd_en, 0);
        chk("t2_stall_valid", o_res_valid, 1);
        chk("t2_stall_busy", o_busy, 1);
        i_res_ready = 1'b1;
        wait_done("t2", 80);
        chk("t2_total_rd_cnt", rd_cnt - rd0, 8);

        // 3: K=0 completes at once with no reads
        rd0 = rd_cnt;
        start_job(8'd0, 8'd5, 10'h111, 10'h222);
        chk("t3_done_pulse", o_done, 1);
        chk("t3_not_busy", o_busy, 0);
        tick();
        chk("t3_done_one_cycle", o_done, 0);
        chk("t3_still_idle", o_busy, 0);
        tick(4);
        chk("t3_no_reads", rd_cnt - rd0, 0);
        chk("t3_done_cnt", done_cnt - done_base, 1);

        // 4: start re-pulsed mid-RUN is ignored
        expect_job(3, 2, 10'h100, 10'h200);
        start_job(8'd3, 8'd2, 10'h100, 10'h200);
        tick();
        i_num_grp  = 8'd5;
        i_num_row  = 8'd1;
        i_act_base = 10'h300;
        i_wgt_base = 10'h300;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
        wait_done("t4", 60);

        // 5: reset mid-RUN with two results queued
        i_res_ready = 1'b0;
        expect_job(8, 1, 10'h000, 10'h000);
        start_job(8'd8, 8'd1, 10'h000, 10'h000);
        for (int i = 0; i < 20 && !o_res_valid; i++) tick();
        tick();
        chk("t5_queued_valid", o_res_valid, 1);
        chk("t5_queued_cnt", dut.fifo_cnt, 3'd2);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", o_busy, 0);
        chk("t5_rst_done", o_done, 0);
        chk("t5_rst_rd_en", {o_act_rd_en, o_wgt_rd_en}, 0);
        chk("t5_rst_addr", {o_act_rd_addr, o_wgt_rd_addr}, 0);
        chk("t5_rst_res", {o_res_valid, o_res_E, o_res_M, o_res_row, o_res_last}, 0);
        chk("t5_rst_state", o_dbg_state, 2'd0);
        act_exp_q.delete();
        wgt_exp_q.delete();
        res_exp_q.delete();
        d0 = done_cnt;
        tick(3);
        i_reset_n   = 1'b1;
        i_res_ready = 1'b1;
        tick(4);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_fifo_empty", o_res_valid, 0);
        expect_job(2, 2, 10'h050, 10'h060);
        start_job(8'd2, 8'd2, 10'h050, 10'h060);
        wait_done("t5_rerun", 60);

        // 6: address wrap at 2^10
        push_exp(10'h3FD, 10'h3FE, 8'd0, 1'b0);
        push_exp(10'h3FE, 10'h3FF, 8'd0, 1'b0);
        push_exp(10'h3FF, 10'h000, 8'd0, 1'b0);
        push_exp(10'h000, 10'h001, 8'd0, 1'b1);
        start_job(8'd4, 8'd1, 10'h3FD, 10'h3FE);
        wait_done("t6", 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
